// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared group width, group-count helper and group propagate/generate type for the subtractor.
package sub_pkg;

    localparam int GRP_W = 4;

    function automatic int nGrp(input int width);
        return width / GRP_W;
    endfunction

    typedef struct packed {
        logic pp;
        logic gg;
    } grp_pg_t;

endpackage

// File: rtl/sub_cla4.sv
// rtl/sub_cla4.sv - 4-bit carry-lookahead slice with group propagate/generate export.
module sub_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] bn,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       pp,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] q;
    logic [3:0] c;

    assign p = a | bn;
    assign g = a & bn;
    assign q = a ^ bn;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign sum = q ^ c;

    // Group terms are independent of cin so the second level can resolve all group carries at once.
    assign pp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/sub_cla_pipe.sv
// rtl/sub_cla_pipe.sv - two-stage pipelined CLA subtractor with valid/ready; SUB_OVF_EN enables signed overflow.
module sub_cla_pipe
    import sub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NGRP = nGrp(WIDTH);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_bn;
    logic             s1_cin;
    logic             s2_ready;

    grp_pg_t          pg [NGRP];
    logic [NGRP:0]    grp_c;
    logic [WIDTH-1:0] sum;

    assign s2_ready = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_a   <= in_a;
            s1_bn  <= ~in_b;
            s1_cin <= !in_bin;
        end
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        sub_cla4 u_cla4 (
            .a   (s1_a[k*GRP_W +: GRP_W]),
            .bn  (s1_bn[k*GRP_W +: GRP_W]),
            .cin (grp_c[k]),
            .sum (sum[k*GRP_W +: GRP_W]),
            .pp  (pg[k].pp),
            .gg  (pg[k].gg)
        );
    end

    // Each group carry is a flat sum of products over all lower groups rather than a ripple chain.
    logic acc;
    logic run;
    always_comb begin
        grp_c = '0;
        acc   = 1'b0;
        run   = 1'b1;
        grp_c[0] = s1_cin;
        for (int k = 0; k < NGRP; k++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc = acc | (run & pg[j].gg);
                run = run & pg[j].pp;
            end
            grp_c[k+1] = acc | (run & s1_cin);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= sum;
                bout   <= !grp_c[NGRP];
                zero   <= ~|sum;
            end
        end
    end

`ifdef SUB_OVF_EN
    // s1_bn holds ~b, so "a and b signs differ" is a == ~b at the MSB.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (s2_ready && s1_valid) begin
            ovf <= (s1_a[WIDTH-1] == s1_bn[WIDTH-1]) & (sum[WIDTH-1] != s1_a[WIDTH-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sub_cla_pipe.sv
// tb/tb_sub_cla_pipe.sv - directed self-checking bench for sub_cla_pipe.
module tb_sub_cla_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        bout;
    logic        zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic exp_ovf3;

    sub_cla_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] b, input logic bin);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic bin, input logic [31:0] r, input logic bo,
                         input logic z, input logic ov);
        put(a, b, bin);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, result, r);
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, bo});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ov});
    endtask

    initial begin
`ifdef SUB_OVF_EN
        exp_ovf3 = 1'b1;
`else
        exp_ovf3 = 1'b0;
`endif
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        step();

        do_op("t1", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        do_op("t2", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        do_op("t3", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, exp_ovf3);
        do_op("t4a", 32'd7, 32'd6, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
        do_op("t4b", 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 32'h0001_FFFF, 1'b1, 1'b0, 1'b0);
        step();

        // Stream 1-1, 9-4, 2-3 with a two-cycle output stall after the first result.
        put(32'd1, 32'd1, 1'b0);
        step();
        put(32'd9, 32'd4, 1'b0);
        step();
        chk("t5_r0_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_r0", result, 32'd0);
        put(32'd2, 32'd3, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("t5_in_ready_full", {31'd0, in_ready}, 32'd0);
        step();
        chk("t5_hold1", result, 32'd0);
        chk("t5_hold1_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_hold1_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("t5_hold2", result, 32'd0);
        chk("t5_hold2_zero", {31'd0, zero}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("t5_in_ready_rel", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t5_r1", result, 32'd5);
        chk("t5_r1_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("t5_r2", result, 32'hFFFF_FFFF);
        chk("t5_r2_bout", {31'd0, bout}, 32'd1);
        step();
        chk("t5_drain", {31'd0, out_valid}, 32'd0);

        // Reset with two ops in flight.
        put(32'd20, 32'd3, 1'b0);
        step();
        put(32'd30, 32'd4, 1'b0);
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_result", result, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("t6_no_ghost", {31'd0, out_valid}, 32'd0);
        do_op("t6_new", 32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_cla_pipe.md
Name: sub_cla_pipe

Overview:
Pipelined WIDTH-bit subtractor: result = in_a - in_b - in_bin, computed as in_a + ~in_b + !in_bin.
- Built from 4-bit carry-lookahead slices that export group propagate/generate, plus a second-level lookahead across groups.
- Two register stages with valid/ready handshakes on both sides.
- Sits beside the adder datapath as the subtract/compare unit feeding downstream flag consumers.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4.
NGRP, WIDTH/4, number of 4-bit lookahead groups (derived; not overridden).

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  input operands valid
in_ready  out  1  block accepts input this cycle
in_a  in  WIDTH  minuend
in_b  in  WIDTH  subtrahend
in_bin  in  1  borrow in
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  WIDTH  (in_a - in_b - in_bin) mod 2^WIDTH
bout  out  1  borrow out; 1 iff in_a < in_b + in_bin (unsigned)
zero  out  1  result == 0
ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Reset: rst low at a rising edge clears s1_valid, out_valid, result, bout, zero and ovf to 0. The S1 data registers are don't-care. Reset mid-operation discards all in-flight items; there is no flush output.
- Stage S1: on in_valid & in_ready, register in_a, ~in_b and cin = !in_bin, and set s1_valid.
- Stage S2 (combinational from the S1 regs):
  - per group: p = a|b', g = a&b', q = a^b'; pp = AND of p; gg = standard 4-bit lookahead.
  - group carry C[k+1] = GG[k] | PP[k]&C[k], expanded as two-level lookahead, with C[0] = cin.
  - sum bit i = q[i] ^ c[i].
  - bout = !C[NGRP]; zero = ~|sum.
- S2 registers into the output regs when s1_valid & s2_ready; out_valid follows.
- Ready chain (combinational):
  - s2_ready = !out_valid | out_ready
  - in_ready = !s1_valid | s2_ready
- S1 update rules:
  - when S1 advances and no new input is accepted, s1_valid clears.
  - simultaneous advance and accept in one cycle is legal and gives full throughput (1 op/cycle).
- Latency: an op accepted at edge k appears on out_valid after edge k+1, i.e. 2 cycles input-to-output with no stall.
- Stall: out_valid & !out_ready holds result/bout/zero/ovf stable. S1 holds its data. in_ready drops only when both stages are full.
- Ordering: strictly in order; no drops, no duplicates.
- Outputs change only at clock edges; no combinational path from in_* to result.

Optional Feature:
SUB_OVF_EN defined:
- ovf is registered alongside result.
- ovf = (a[MSB] != b[MSB]) & (result[MSB] != a[MSB]), using the original in_b and in_bin.
SUB_OVF_EN undefined:
- ovf is tied 0 and no overflow logic is synthesised.
The port exists in both builds.

Decomposition:
Shared package sub_pkg:
- localparam GRP_W = 4
- function nGrp(width)
- typedef struct packed { logic pp; logic gg; } grp_pg_t
Sub-module sub_cla4:
- 4-bit slice: inputs a, b' (already inverted), cin.
- outputs sum[3:0], pp, gg.
- purely combinational; instantiated NGRP times in S2.

Test Plan:
1. in_a=5, in_b=3, in_bin=0, out_ready=1 -> two cycles later result=2, bout=0, zero=0, ovf=0.
2. in_a=0, in_b=1, in_bin=0 -> result=0xFFFFFFFF, bout=1, zero=0, ovf=0.
3. in_a=0x80000000, in_b=1, in_bin=0 -> result=0x7FFFFFFF, bout=0, ovf=1 with SUB_OVF_EN, 0 without.
4. in_a=7, in_b=6, in_bin=1 -> result=0, zero=1, bout=0. Then in_a=0x0000FFFF, in_b=0xFFFF0000 -> result=0x0001FFFF, bout=1 (carry across all groups).
5. Stream ops {1-1, 9-4, 2-3} back-to-back with out_ready low for 2 cycles after the first out_valid:
   - in_ready drops once both stages are full.
   - results 0, 5, 0xFFFFFFFF emerge in order, each held stable while stalled.
6. Two ops in flight, rst low for one edge -> out_valid=0, result=0, in_ready=1 next cycle. A new op 10-4 then gives result=6 after 2 cycles.
